// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - ctrl_state_e : controller states (RUN, MEM_WAIT)
//   - FWD_*        : EX operand source selects driven to the EX-stage muxes
//   - WB_SEL_MEM   : writeback-select encoding the decoder uses for loads
//   - reg_match()  : "producer writes a non-x0 register read by the consumer"
package pipe_ctrl_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } ctrl_state_e;

   localparam logic [1:0] FWD_REG = 2'd0;
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;

   // Load writeback encoding of the decoder (0 = ALU, 1 = memory, 2 = PC+4).
   localparam logic [1:0] WB_SEL_MEM = 2'd1;

   // x0 is hard-wired to zero, so a write to it never creates a dependency.
   function automatic logic reg_match(input logic       wen,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs);
      return wen && (rd != 5'd0) && (rd == rs);
   endfunction

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one EX-stage source operand (purely combinational).
// Ports:
//   ex_rs_i     : source register read by the instruction in EX
//   mem_rd_i    : destination of the instruction in MEM, mem_regWEn_i its write enable
//   wb_rd_i     : destination of the instruction in WB,  wb_regWEn_i its write enable
//   fwd_sel_o   : FWD_MEM / FWD_WB / FWD_REG
// MEM holds the younger result, so it takes priority over WB.
module fwd_unit
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] ex_rs_i,
   input  logic [4:0] mem_rd_i,
   input  logic       mem_regWEn_i,
   input  logic [4:0] wb_rd_i,
   input  logic       wb_regWEn_i,
   output logic [1:0] fwd_sel_o
);

   always_comb begin
      fwd_sel_o = FWD_REG;
      if (reg_match(mem_regWEn_i, mem_rd_i, ex_rs_i)) begin
         fwd_sel_o = FWD_MEM;
      end else if (reg_match(wb_regWEn_i, wb_rd_i, ex_rs_i)) begin
         fwd_sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline controller of the 5-stage RV32I core.
// Drives stage-register enables/flushes, the EX forwarding selects, freezes the
// pipeline during outstanding data-memory accesses and counts stalled cycles.
// Ports:
//   clk, reset_n                  : clock, asynchronous active-low reset
//   id_*                          : source registers read by the ID instruction
//   ex_*                          : EX instruction sources/destination, wb select, redirect
//   mem_rd_i/mem_regWEn_i/mem_req_i, dmem_ack_i : MEM instruction and memory handshake
//   wb_rd_i/wb_regWEn_i           : WB instruction destination
//   stall_cnt_clr_i               : synchronous clear of the stall counter
//   *_en_o / *_flush_o            : stage-register controls
//   fwd_a_sel_o / fwd_b_sel_o     : EX operand A/B source selects
//   mem_err_o                     : one-cycle pulse when a memory access times out
//   stall_cnt_o                   : saturating count of cycles with pc_en_o low
// Memory handshake: a MEM access (mem_req_i) completes in the cycle dmem_ack_i is
// high; until then the whole pipeline holds, and the inputs of every stage are
// therefore stable, so held-off redirects/load-uses are re-evaluated on exit.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_use_rs1_i,
   input  logic             id_use_rs2_i,
   input  logic [4:0]       ex_rs1_i,
   input  logic [4:0]       ex_rs2_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             ex_regWEn_i,
   input  logic [1:0]       ex_wb_sel_i,
   input  logic             ex_redirect_i,
   input  logic [4:0]       mem_rd_i,
   input  logic             mem_regWEn_i,
   input  logic             mem_req_i,
   input  logic             dmem_ack_i,
   input  logic [4:0]       wb_rd_i,
   input  logic             wb_regWEn_i,
   input  logic             stall_cnt_clr_i,
   output logic             pc_en_o,
   output logic             if_id_en_o,
   output logic             if_id_flush_o,
   output logic             id_ex_en_o,
   output logic             id_ex_flush_o,
   output logic             ex_mem_en_o,
   output logic             mem_wb_en_o,
   output logic [1:0]       fwd_a_sel_o,
   output logic [1:0]       fwd_b_sel_o,
   output logic             mem_err_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   localparam logic [15:0] TIMEOUT_CNT = 16'(MEM_TIMEOUT);

   ctrl_state_e      state_q, state_d;
   logic [15:0]      wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic       load_use;
   logic       timeout;
   logic       advance;
   logic       pc_en_c, if_id_en_c, if_id_flush_c;
   logic       id_ex_en_c, id_ex_flush_c, ex_mem_en_c, mem_wb_en_c;
   logic       mem_err_c;
   logic [1:0] fwd_a_raw, fwd_b_raw;

   fwd_unit u_fwd_a (
      .ex_rs_i      (ex_rs1_i),
      .mem_rd_i     (mem_rd_i),
      .mem_regWEn_i (mem_regWEn_i),
      .wb_rd_i      (wb_rd_i),
      .wb_regWEn_i  (wb_regWEn_i),
      .fwd_sel_o    (fwd_a_raw)
   );

   fwd_unit u_fwd_b (
      .ex_rs_i      (ex_rs2_i),
      .mem_rd_i     (mem_rd_i),
      .mem_regWEn_i (mem_regWEn_i),
      .wb_rd_i      (wb_rd_i),
      .wb_regWEn_i  (wb_regWEn_i),
      .fwd_sel_o    (fwd_b_raw)
   );

   // Load in EX whose result the ID instruction needs: not available until MEM.
   always_comb begin
      load_use = ex_regWEn_i && (ex_wb_sel_i == WB_SEL_MEM) && (ex_rd_i != 5'd0) &&
                 ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                  (id_use_rs2_i && (id_rs2_i == ex_rd_i)));
   end

   // Next state and stage controls.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      advance    = 1'b1;
      mem_err_c  = 1'b0;
      timeout    = (state_q == MEM_WAIT) && (wait_cnt_q == TIMEOUT_CNT);

      case (state_q)
         RUN: begin
            if (mem_req_i && !dmem_ack_i) begin
               advance    = 1'b0;
               state_d    = MEM_WAIT;
               wait_cnt_d = 16'd0;
            end
         end
         MEM_WAIT: begin
            if (dmem_ack_i || timeout) begin
               // An ack in the timeout cycle still counts as a clean completion.
               state_d   = RUN;
               mem_err_c = !dmem_ack_i;
            end else begin
               advance    = 1'b0;
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase

      pc_en_c       = advance;
      if_id_en_c    = advance;
      id_ex_en_c    = advance;
      ex_mem_en_c   = advance;
      mem_wb_en_c   = advance;
      if_id_flush_c = 1'b0;
      id_ex_flush_c = 1'b0;

      // Redirect squashes the ID instruction, so a load-use on it is moot.
      if (advance) begin
         if (ex_redirect_i) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
         end else if (load_use) begin
            pc_en_c       = 1'b0;
            if_id_en_c    = 1'b0;
            id_ex_flush_c = 1'b1;
         end
      end
   end

   // While reset is held every stage register is frozen and bubbled.
   assign pc_en_o       = reset_n & pc_en_c;
   assign if_id_en_o    = reset_n & if_id_en_c;
   assign id_ex_en_o    = reset_n & id_ex_en_c;
   assign ex_mem_en_o   = reset_n & ex_mem_en_c;
   assign mem_wb_en_o   = reset_n & mem_wb_en_c;
   assign if_id_flush_o = ~reset_n | if_id_flush_c;
   assign id_ex_flush_o = ~reset_n | id_ex_flush_c;
   assign fwd_a_sel_o   = reset_n ? fwd_a_raw : FWD_REG;
   assign fwd_b_sel_o   = reset_n ? fwd_b_raw : FWD_REG;
   assign mem_err_o     = reset_n & mem_err_c;
   assign stall_cnt_o   = stall_cnt_q;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_cnt_clr_i) begin
         stall_cnt_d = '0;
      end else if (!pc_en_o && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= RUN;
         wait_cnt_q  <= 16'd0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4 so the stall
// counter saturates within a short run). Inputs change 2 time units after each
// rising edge; outputs are checked 1 unit later, mid-cycle.
module tb_pipe_hazard_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int unsigned CNT_W = 4;

   // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
   localparam logic [6:0] C_RESET = 7'b0010100;
   localparam logic [6:0] C_RUN   = 7'b1101011;
   localparam logic [6:0] C_LU    = 7'b0001111;
   localparam logic [6:0] C_RDR   = 7'b1111111;
   localparam logic [6:0] C_FRZ   = 7'b0000000;

   logic             clk;
   logic             reset_n;
   logic [4:0]       id_rs1_i, id_rs2_i;
   logic             id_use_rs1_i, id_use_rs2_i;
   logic [4:0]       ex_rs1_i, ex_rs2_i, ex_rd_i;
   logic             ex_regWEn_i;
   logic [1:0]       ex_wb_sel_i;
   logic             ex_redirect_i;
   logic [4:0]       mem_rd_i;
   logic             mem_regWEn_i, mem_req_i, dmem_ack_i;
   logic [4:0]       wb_rd_i;
   logic             wb_regWEn_i;
   logic             stall_cnt_clr_i;
   logic             pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o;
   logic             ex_mem_en_o, mem_wb_en_o;
   logic [1:0]       fwd_a_sel_o, fwd_b_sel_o;
   logic             mem_err_o;
   logic [CNT_W-1:0] stall_cnt_o;

   int vectors     = 0;
   int miscompares = 0;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .id_rs1_i        (id_rs1_i),
      .id_rs2_i        (id_rs2_i),
      .id_use_rs1_i    (id_use_rs1_i),
      .id_use_rs2_i    (id_use_rs2_i),
      .ex_rs1_i        (ex_rs1_i),
      .ex_rs2_i        (ex_rs2_i),
      .ex_rd_i         (ex_rd_i),
      .ex_regWEn_i     (ex_regWEn_i),
      .ex_wb_sel_i     (ex_wb_sel_i),
      .ex_redirect_i   (ex_redirect_i),
      .mem_rd_i        (mem_rd_i),
      .mem_regWEn_i    (mem_regWEn_i),
      .mem_req_i       (mem_req_i),
      .dmem_ack_i      (dmem_ack_i),
      .wb_rd_i         (wb_rd_i),
      .wb_regWEn_i     (wb_regWEn_i),
      .stall_cnt_clr_i (stall_cnt_clr_i),
      .pc_en_o         (pc_en_o),
      .if_id_en_o      (if_id_en_o),
      .if_id_flush_o   (if_id_flush_o),
      .id_ex_en_o      (id_ex_en_o),
      .id_ex_flush_o   (id_ex_flush_o),
      .ex_mem_en_o     (ex_mem_en_o),
      .mem_wb_en_o     (mem_wb_en_o),
      .fwd_a_sel_o     (fwd_a_sel_o),
      .fwd_b_sel_o     (fwd_b_sel_o),
      .mem_err_o       (mem_err_o),
      .stall_cnt_o     (stall_cnt_o)
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Driver tasks
   task automatic idle();
      id_rs1_i = 5'd0; id_rs2_i = 5'd0; id_use_rs1_i = 1'b0; id_use_rs2_i = 1'b0;
      ex_rs1_i = 5'd0; ex_rs2_i = 5'd0; ex_rd_i = 5'd0; ex_regWEn_i = 1'b0;
      ex_wb_sel_i = 2'd0; ex_redirect_i = 1'b0;
      mem_rd_i = 5'd0; mem_regWEn_i = 1'b0; mem_req_i = 1'b0; dmem_ack_i = 1'b0;
      wb_rd_i = 5'd0; wb_regWEn_i = 1'b0; stall_cnt_clr_i = 1'b0;
   endtask

   // lw x5 in EX; ID instruction reads x5 via rs1 (sel=1) or rs2 (sel=0).
   task automatic load_use_x5(input logic via_rs1);
      ex_regWEn_i = 1'b1; ex_wb_sel_i = WB_SEL_MEM; ex_rd_i = 5'd5;
      id_rs1_i = via_rs1 ? 5'd5 : 5'd1; id_use_rs1_i = 1'b1;
      id_rs2_i = via_rs1 ? 5'd1 : 5'd5; id_use_rs2_i = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Scoreboard
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctrl(input string tag, input logic [6:0] exp);
      chk(tag, 32'({pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
                    ex_mem_en_o, mem_wb_en_o}), 32'(exp));
   endtask

   initial begin
      reset_n = 1'b0;
      idle();
      ex_rs1_i = 5'd7; ex_rs2_i = 5'd7; mem_rd_i = 5'd7; mem_regWEn_i = 1'b1;
      #2;
      chk_ctrl("reset_ctrl", C_RESET);
      chk("reset_fwd", 32'({fwd_a_sel_o, fwd_b_sel_o}), 32'({FWD_REG, FWD_REG}));
      chk("reset_err", 32'(mem_err_o), 32'd0);
      chk("reset_cnt", 32'(stall_cnt_o), 32'd0);
      #10;
      reset_n = 1'b1;

      // Plain run
      step(); idle(); #1;
      chk_ctrl("idle_ctrl", C_RUN);

      // Load-use on rs1: one-cycle bubble
      step(); idle(); load_use_x5(1'b1); #1;
      chk_ctrl("lu_rs1_ctrl", C_LU);

      // Load now in WB, dependent add in EX
      step(); idle();
      ex_rs1_i = 5'd5; ex_rs2_i = 5'd1; ex_rd_i = 5'd6; ex_regWEn_i = 1'b1;
      wb_rd_i = 5'd5; wb_regWEn_i = 1'b1; #1;
      chk_ctrl("lu_after_ctrl", C_RUN);
      chk("lu_after_fwd_a", 32'(fwd_a_sel_o), 32'(FWD_WB));
      chk("lu_after_fwd_b", 32'(fwd_b_sel_o), 32'(FWD_REG));
      chk("lu_after_cnt", 32'(stall_cnt_o), 32'd1);

      // Forwarding priority and x0
      step(); idle();
      ex_rs1_i = 5'd7; ex_rs2_i = 5'd7;
      mem_rd_i = 5'd7; mem_regWEn_i = 1'b1; wb_rd_i = 5'd7; wb_regWEn_i = 1'b1; #1;
      chk("fwd_mem_prio", 32'({fwd_a_sel_o, fwd_b_sel_o}), 32'({FWD_MEM, FWD_MEM}));
      step(); idle();
      mem_rd_i = 5'd7; mem_regWEn_i = 1'b0; wb_rd_i = 5'd7; wb_regWEn_i = 1'b1;
      ex_rs1_i = 5'd7; ex_rs2_i = 5'd7; #1;
      chk("fwd_wb_only", 32'({fwd_a_sel_o, fwd_b_sel_o}), 32'({FWD_WB, FWD_WB}));
      step(); idle();
      mem_rd_i = 5'd0; mem_regWEn_i = 1'b1; wb_rd_i = 5'd0; wb_regWEn_i = 1'b1; #1;
      chk("fwd_x0", 32'({fwd_a_sel_o, fwd_b_sel_o}), 32'({FWD_REG, FWD_REG}));

      // Load-use on rs2, then non-hazard variants
      step(); idle(); load_use_x5(1'b0); #1;
      chk_ctrl("lu_rs2_ctrl", C_LU);
      step(); idle(); load_use_x5(1'b1); ex_rd_i = 5'd0; id_rs1_i = 5'd0; #1;
      chk_ctrl("lu_x0_ctrl", C_RUN);
      step(); idle(); load_use_x5(1'b1); ex_wb_sel_i = 2'd0; #1;
      chk_ctrl("lu_alu_ctrl", C_RUN);

      // Redirect overrides load-use
      step(); idle(); load_use_x5(1'b1); ex_redirect_i = 1'b1; #1;
      chk_ctrl("lu_redirect_ctrl", C_RDR);
      step(); idle(); #1;
      chk("lu_redirect_cnt", 32'(stall_cnt_o), 32'd2);

      // Memory access acked immediately
      step(); idle(); mem_req_i = 1'b1; dmem_ack_i = 1'b1; #1;
      chk_ctrl("mem_fast_ctrl", C_RUN);

      // Three wait cycles, redirect held off until the ack cycle
      step(); idle(); mem_req_i = 1'b1; #1;
      chk_ctrl("mem_wait0_ctrl", C_FRZ);
      step(); ex_redirect_i = 1'b1; #1;
      chk_ctrl("mem_wait1_ctrl", C_FRZ);
      step(); #1;
      chk_ctrl("mem_wait2_ctrl", C_FRZ);
      step(); dmem_ack_i = 1'b1; #1;
      chk_ctrl("mem_ack_ctrl", C_RDR);
      chk("mem_ack_err", 32'(mem_err_o), 32'd0);
      step(); idle(); #1;
      chk_ctrl("mem_after_ctrl", C_RUN);
      chk("mem_after_cnt", 32'(stall_cnt_o), 32'd5);

      // Timeout after 4 MEM_WAIT cycles, load-use held off to the exit cycle
      step(); idle(); mem_req_i = 1'b1; load_use_x5(1'b1); #1;
      chk_ctrl("to_entry_ctrl", C_FRZ);
      for (int i = 0; i < 4; i++) begin
         step(); #1;
         chk_ctrl("to_wait_ctrl", C_FRZ);
         chk("to_wait_err", 32'(mem_err_o), 32'd0);
      end
      step(); #1;
      chk_ctrl("to_exit_ctrl", C_LU);
      chk("to_exit_err", 32'(mem_err_o), 32'd1);
      step(); idle(); #1;
      chk_ctrl("to_run_ctrl", C_RUN);
      chk("to_run_err", 32'(mem_err_o), 32'd0);
      chk("to_run_cnt", 32'(stall_cnt_o), 32'd11);

      // Saturation at all-ones, then clear wins over increment
      for (int i = 0; i < 6; i++) begin
         step(); idle(); load_use_x5(1'b1);
      end
      step(); stall_cnt_clr_i = 1'b1; #1;
      chk("sat_cnt", 32'(stall_cnt_o), 32'd15);
      chk_ctrl("sat_clr_ctrl", C_LU);
      step(); idle(); #1;
      chk("clr_cnt", 32'(stall_cnt_o), 32'd0);

      // Reset asserted in MEM_WAIT
      step(); idle(); mem_req_i = 1'b1;
      step(); #1;
      chk("rst_wait_cnt", 32'(stall_cnt_o), 32'd1);
      reset_n = 1'b0; #1;
      chk_ctrl("rst_wait_ctrl", C_RESET);
      chk("rst_wait_cnt0", 32'(stall_cnt_o), 32'd0);
      chk("rst_wait_err", 32'(mem_err_o), 32'd0);
      step(); idle(); reset_n = 1'b1;
      step(); #1;
      chk_ctrl("rst_after_ctrl", C_RUN);
      chk("rst_after_cnt", 32'(stall_cnt_o), 32'd0);
      chk("rst_after_err", 32'(mem_err_o), 32'd0);

      // Final report
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage RV32I core. It drives the enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It also generates the EX-stage operand forwarding selects and freezes the pipeline while a multi-cycle data-memory access is outstanding. It resolves load-use hazards, taken-branch/jump redirects, memory wait and timeout.

Parameters:
MEM_TIMEOUT, 255, number of cycles in MEM_WAIT without ack before timeout is declared (1..2^16-1)
CNT_W, 32, width of stall performance counter

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous, active-low reset
id_rs1_i  input  5  rs1 of instruction in ID
id_rs2_i  input  5  rs2 of instruction in ID
id_use_rs1_i  input  1  ID instruction reads rs1
id_use_rs2_i  input  1  ID instruction reads rs2
ex_rs1_i  input  5  rs1 of instruction in EX
ex_rs2_i  input  5  rs2 of instruction in EX
ex_rd_i  input  5  rd in EX
ex_regWEn_i  input  1  EX instruction writes rd
ex_wb_sel_i  input  2  EX writeback select
ex_redirect_i  input  1  EX branch taken or jump; PC must load target
mem_rd_i  input  5  rd in MEM
mem_regWEn_i  input  1  MEM instruction writes rd
mem_req_i  input  1  MEM instruction accesses data memory
dmem_ack_i  input  1  data memory completes access this cycle
wb_rd_i  input  5  rd in WB
wb_regWEn_i  input  1  WB instruction writes rd
stall_cnt_clr_i  input  1  synchronous clear of stall counter
pc_en_o  output  1  PC update enable
if_id_en_o  output  1  IF/ID enable
if_id_flush_o  output  1  IF/ID flush (bubble)
id_ex_en_o  output  1  ID/EX enable (flush has priority inside register)
id_ex_flush_o  output  1  ID/EX flush
ex_mem_en_o  output  1  EX/MEM enable
mem_wb_en_o  output  1  MEM/WB enable
fwd_a_sel_o  output  2  EX operand A source
fwd_b_sel_o  output  2  EX operand B source
mem_err_o  output  1  one-cycle pulse on data-memory timeout
stall_cnt_o  output  CNT_W  saturating count of stalled cycles

Behaviour:
- States: RUN, MEM_WAIT. Reset -> RUN, wait counter 0, stall_cnt 0, mem_err_o 0.
- While reset_n low: all *_en_o 0; if_id_flush_o and id_ex_flush_o 1; fwd selects 0.
- Load-use (RUN only): ex_regWEn_i and ex_wb_sel_i==WB_SEL_MEM and ex_rd_i!=0 and ((id_use_rs1_i and id_rs1_i==ex_rd_i) or (id_use_rs2_i and id_rs2_i==ex_rd_i)).
  - Response, same cycle, exactly one cycle: pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1. Other enables stay 1.
- Redirect (RUN only): ex_redirect_i=1 -> if_id_flush_o=1, id_ex_flush_o=1, pc_en_o=1. Redirect overrides load-use in the same cycle (no stall, no double bubble).
- Memory wait:
  - In RUN, mem_req_i=1 and dmem_ack_i=0 -> enter MEM_WAIT. All enables are 0 in that cycle and every MEM_WAIT cycle. Flushes 0 in MEM_WAIT.
  - mem_req_i=1 with dmem_ack_i=1 in RUN -> no stall.
- MEM_WAIT exit:
  - dmem_ack_i=1 -> all enables 1 in that cycle, redirect/load-use rules re-evaluated normally, next state RUN.
  - Wait counter reaches MEM_TIMEOUT -> mem_err_o=1 for one cycle. Pipeline advances as if acked; next state RUN.
- Redirect or load-use arriving during MEM_WAIT is held off (EX frozen, inputs persist) and applied on the exit cycle.
- Wait counter: cleared on entry, increments each MEM_WAIT cycle.
- Forwarding (combinational, every cycle):
  - fwd_a_sel_o=FWD_MEM if mem_regWEn_i and mem_rd_i!=0 and mem_rd_i==ex_rs1_i.
  - Else FWD_WB on the same match against wb_rd_i/wb_regWEn_i.
  - Else FWD_REG.
  - MEM has priority over WB. x0 is never forwarded. fwd_b_sel_o is identical, using ex_rs2_i.
- stall_cnt_o:
  - Increments on each cycle with pc_en_o=0 outside reset; saturates at all-ones.
  - stall_cnt_clr_i wins over increment.
- Reset asserted mid-MEM_WAIT -> immediate RUN, counters 0, no mem_err_o.

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum {RUN, MEM_WAIT}.
  - FWD_REG=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2.
  - WB_SEL_MEM, equal to the decoder's load writeback encoding.
- Sub-module fwd_unit: purely combinational forwarding for one operand, instantiated twice.

Test Plan:
- lw x5 in EX, ID add x6,x5,x1 (use_rs1) -> exactly one cycle pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1. Next cycle load in WB, fwd_a_sel_o=FWD_WB.
- Load-use on x5 with ex_redirect_i=1 same cycle -> if_id_flush_o=1, id_ex_flush_o=1, pc_en_o=1, stall_cnt unchanged.
- mem_req_i=1, dmem_ack_i low 3 cycles then high -> 3 cycles all enables 0, stall_cnt +3, ack cycle all enables 1.
- MEM_TIMEOUT=4, no ack -> mem_err_o pulses in 5th wait cycle, enables 1 that cycle, state RUN.
- ex_rs1=ex_rs2=7, mem_rd=7 and wb_rd=7 both writing -> both selects FWD_MEM. Same case with rd=0 -> FWD_REG.
- reset_n low during MEM_WAIT -> enables 0, flushes 1. After release: RUN, stall_cnt 0, mem_err_o 0.
